// File: rtl/iob_sseg_scan.sv
// Seven-segment display scanner. It snapshots the digits once per frame and
// drives active-low one-hot anodes and decoded cathodes, with a dead time between digits.
module iob_sseg_scan #(
  parameter int NDIGITS = 4,
  parameter int DIV_W   = 16,
  parameter int DEAD_W  = 8,
  localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [4*NDIGITS-1:0]   digits_i,
  input  logic [NDIGITS-1:0]     dp_i,
  input  logic [NDIGITS-1:0]     blank_i,
  input  logic [DIV_W-1:0]       period_i,
  input  logic [DEAD_W-1:0]      dead_i,
  output logic [7:0]             cathode_o,
  output logic [NDIGITS-1:0]     anode_o,
  output logic [IDX_W-1:0]       digit_idx_o,
  output logic                   frame_tick_o
);

  localparam int CNT_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NDIGITS-1:0][3:0]     snap_digits_q, snap_digits_d;
  logic [NDIGITS-1:0]          snap_dp_q, snap_dp_d;
  logic [NDIGITS-1:0]          snap_blank_q, snap_blank_d;
  logic [NDIGITS-1:0]          anode_q, anode_d;
  logic [7:0]                  cathode_q, cathode_d;
  logic                        tick_q, tick_d;
  logic                        last_digit;

  // Active-low segment pattern with the decimal point off (bit 7 high).
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] seg;
    case (v)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  assign last_digit = (idx_q == IDX_W'(NDIGITS - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_blank_d  = snap_blank_q;
    tick_d        = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d       = S_BLANK;
          cnt_d         = CNT_W'(dead_i);
          idx_d         = '0;
          snap_digits_d = digits_i;
          snap_dp_d     = dp_i;
          snap_blank_d  = blank_i;
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_d = S_ON;
            cnt_d   = CNT_W'(period_i);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_ON: begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = CNT_W'(dead_i);
            if (last_digit) begin
              // Frame boundary: wrap and take a new snapshot for the next frame.
              idx_d         = '0;
              tick_d        = 1'b1;
              snap_digits_d = digits_i;
              snap_dp_d     = dp_i;
              snap_blank_d  = blank_i;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs come from next-state values, so the anodes and cathodes register on the same edge.
    anode_d   = '1;
    cathode_d = 8'hFF;
    if (state_d == S_ON && !snap_blank_d[idx_d]) begin
      anode_d[idx_d] = 1'b0;
      cathode_d      = hex_to_seg(snap_digits_d[idx_d]);
      if (snap_dp_d[idx_d]) cathode_d[7] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the snapshot registers are reset along with the control state so that no X can reach the pins after reset.
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      anode_q       <= '1;
      cathode_q     <= 8'hFF;
      tick_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; every flop samples the values from before the edge.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      tick_q        <= tick_d;
    end
  end

  assign anode_o      = anode_q;
  assign cathode_o    = cathode_q;
  assign digit_idx_o  = idx_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_iob_sseg_scan.sv
// Bench for iob_sseg_scan. A frame-position model predicts the outputs on every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_iob_sseg_scan;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic [15:0] period_i = 16'd3;
  logic [7:0]  dead_i = 8'd1;
  logic [7:0]  cathode_o;
  logic [3:0]  anode_o;
  logic [1:0]  digit_idx_o;
  logic        frame_tick_o;

  int n_cmp = 0;
  int n_fail = 0;

  iob_sseg_scan #(.NDIGITS(N), .DIV_W(16), .DEAD_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .blank_i      (blank_i),
    .period_i     (period_i),
    .dead_i       (dead_i),
    .cathode_o    (cathode_o),
    .anode_o      (anode_o),
    .digit_idx_o  (digit_idx_o),
    .frame_tick_o (frame_tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The model tracks the position in the frame since the scan started.
  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  bit          m_active = 1'b0;
  int          m_p, m_dead, m_per, m_slot, m_d, m_r;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  exp_an;
  logic [7:0]  exp_cat;
  logic [1:0]  exp_idx;
  logic        exp_tick, cat_valid;

  always begin
    @(posedge clk);
    if (!rst) begin
      m_active = 1'b0;
      m_p      = 0;
    end else if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_p      = 0;
      m_dig    = digits_i;
      m_dp     = dp_i;
      m_blank  = blank_i;
      m_dead   = int'(dead_i);
      m_per    = int'(period_i);
    end else begin
      m_p++;
      if (m_p % (N * (m_dead + m_per + 2)) == 0) begin
        m_dig   = digits_i;
        m_dp    = dp_i;
        m_blank = blank_i;
      end
    end
    #1;
    exp_an    = 4'hF;
    exp_cat   = 8'hFF;
    exp_idx   = 2'd0;
    exp_tick  = 1'b0;
    cat_valid = 1'b1;
    if (m_active) begin
      m_slot   = m_dead + m_per + 2;
      m_d      = (m_p / m_slot) % N;
      m_r      = m_p % m_slot;
      exp_idx  = 2'(m_d);
      exp_tick = (m_p > 0) && (m_p % (m_slot * N) == 0);
      if (m_r > m_dead) begin
        if (m_blank[m_d]) cat_valid = 1'b0;
        else begin
          exp_an[m_d] = 1'b0;
          exp_cat = seg_tab[m_dig[4*m_d +: 4]] & (m_dp[m_d] ? 8'h7F : 8'hFF);
        end
      end
    end
    check("model_anode", 32'(anode_o), 32'(exp_an));
    if (cat_valid) check("model_cathode", 32'(cathode_o), 32'(exp_cat));
    check("model_idx", 32'(digit_idx_o), 32'(exp_idx));
    check("model_tick", 32'(frame_tick_o), 32'(exp_tick));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the falling edge during scan position 0.
  task automatic start_scan();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_scan();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] dp_tab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                              8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};
  int ticks;

  initial begin
    step(2);
    check("rst_anode", 32'(anode_o), 32'hF);
    check("rst_cathode", 32'(cathode_o), 32'hFF);
    check("rst_tick", 32'(frame_tick_o), 32'h0);
    rst = 1'b1;
    step(2);
    check("idle_anode", 32'(anode_o), 32'hF);

    digits_i = 16'h3210;
    start_scan();
    check("basic_p0_anode", 32'(anode_o), 32'hF);
    step(2);
    check("basic_p2_anode", 32'(anode_o), 32'hE);
    check("basic_p2_cathode", 32'(cathode_o), 32'hC0);
    step(3);
    check("basic_p5_anode", 32'(anode_o), 32'hE);
    step(1);
    check("basic_p6_anode", 32'(anode_o), 32'hF);
    step(2);
    check("basic_p8_anode", 32'(anode_o), 32'hD);
    check("basic_p8_cathode", 32'(cathode_o), 32'hF9);
    check("basic_p8_idx", 32'(digit_idx_o), 32'h1);
    step(6);
    check("basic_p14_anode", 32'(anode_o), 32'hB);
    check("basic_p14_cathode", 32'(cathode_o), 32'hA4);
    step(6);
    check("basic_p20_anode", 32'(anode_o), 32'h7);
    check("basic_p20_cathode", 32'(cathode_o), 32'hB0);
    step(4);
    check("basic_p24_tick", 32'(frame_tick_o), 32'h1);
    check("basic_p24_idx", 32'(digit_idx_o), 32'h0);
    step(1);
    check("basic_p25_tick", 32'(frame_tick_o), 32'h0);
    ticks = 0;
    for (int i = 0; i < 48; i++) begin
      step(1);
      if (frame_tick_o === 1'b1) ticks++;
    end
    check("basic_tick_count", 32'(ticks), 32'd2);
    stop_scan();

    dp_i = 4'b0001;
    for (int v = 0; v < 16; v++) begin
      digits_i = {12'h000, 4'(v)};
      start_scan();
      step(2);
      check("decode_dp", 32'(cathode_o), 32'(dp_tab[v]));
      stop_scan();
    end

    dp_i = 4'b0000;
    digits_i = 16'h1111;
    start_scan();
    step(8);
    digits_i = 16'h2222;
    check("snap_p8_cathode", 32'(cathode_o), 32'hF9);
    step(6);
    check("snap_p14_cathode", 32'(cathode_o), 32'hF9);
    step(6);
    check("snap_p20_cathode", 32'(cathode_o), 32'hF9);
    step(4);
    check("snap_p24_tick", 32'(frame_tick_o), 32'h1);
    step(2);
    check("snap_p26_cathode", 32'(cathode_o), 32'hA4);
    stop_scan();

    blank_i = 4'b0100;
    digits_i = 16'h3210;
    start_scan();
    step(14);
    check("blank_p14_anode", 32'(anode_o), 32'hF);
    step(10);
    check("blank_p24_tick", 32'(frame_tick_o), 32'h1);
    step(24);
    check("blank_p48_tick", 32'(frame_tick_o), 32'h1);
    step(3);
    check("blank_p51_anode", 32'(anode_o), 32'hE);
    en = 1'b0;
    step(1);
    check("endrop_anode", 32'(anode_o), 32'hF);
    check("endrop_cathode", 32'(cathode_o), 32'hFF);
    blank_i = 4'b0000;
    en = 1'b1;
    step(1);
    check("restart_p0_anode", 32'(anode_o), 32'hF);
    step(2);
    check("restart_p2_anode", 32'(anode_o), 32'hE);
    check("restart_p2_idx", 32'(digit_idx_o), 32'h0);

    step(13);
    check("midrst_p15_anode", 32'(anode_o), 32'hB);
    rst = 1'b0;
    step(1);
    check("midrst_anode", 32'(anode_o), 32'hF);
    check("midrst_cathode", 32'(cathode_o), 32'hFF);
    check("midrst_idx", 32'(digit_idx_o), 32'h0);
    check("midrst_tick", 32'(frame_tick_o), 32'h0);
    rst = 1'b1;
    step(1);
    step(2);
    check("resume_p2_anode", 32'(anode_o), 32'hE);
    check("resume_p2_cathode", 32'(cathode_o), 32'hC0);
    step(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_sseg_scan.md
# iob_sseg_scan

Time-multiplexed seven-segment display scanner that sits directly downstream of the GPIO peripheral's cathode/anode path, between the software-visible display registers and the board pins. It takes a packed hexadecimal display value, per-digit decimal-point and blank masks, and per-slot timing settings. It then drives one-hot active-low anode strobes and decoded active-low cathode patterns, with a programmable dead time between digits to suppress ghosting. Input values are snapshotted once per frame so a display frame never shows a mix of old and new digits.

## Interface
- `NDIGITS`, 4: number of multiplexed digits, 1..8.
- `DIV_W`, 16: width of the per-digit on-time counter.
- `DEAD_W`, 8: width of the dead-time counter.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-low reset.
- `en` input 1: scan enable.
- `digits_i` input 4*NDIGITS: hex nibble per digit; digit k is `[4k+3:4k]`.
- `dp_i` input NDIGITS: decimal point on, per digit.
- `blank_i` input NDIGITS: digit k is suppressed when its bit is 1.
- `period_i` input DIV_W: ON slot length is period_i+1 cycles.
- `dead_i` input DEAD_W: BLANK slot length is dead_i+1 cycles.
- `cathode_o` output 8: active-low segments; bit 7 = dp, bits 6..0 = g..a.
- `anode_o` output NDIGITS: active-low digit strobes, at most one bit low at any time.
- `digit_idx_o` output $clog2(NDIGITS) (min 1): index of the current digit.
- `frame_tick_o` output 1: one-cycle pulse when the last digit's ON slot ends.

## Operation
- FSM states:
  - IDLE: all outputs off.
  - BLANK: dead time; anodes all 1, cathodes all 1.
  - ON: anode_o[idx]=0, cathode_o = decode(snap digit idx).
- A single down-counter `cnt` is shared by BLANK and ON. `cnt` is loaded from dead_i on entry to BLANK and from period_i on entry to ON. The slot ends on the cycle `cnt`==0.
- Transitions:
  - IDLE→BLANK when en=1. This edge also sets idx=0 and snapshots digits_i/dp_i/blank_i.
  - BLANK→ON when `cnt`==0.
  - ON→BLANK when `cnt`==0. On this edge idx advances by 1.
  - If the advance would pass NDIGITS-1, idx wraps to 0. The same edge raises frame_tick_o, re-snapshots digits_i/dp_i/blank_i, and passes through BLANK as usual.
  - Any state→IDLE when en=0. This takes priority over all other transitions.
- period_i and dead_i are sampled only at counter load, so a change takes effect at the next slot.
- A blanked digit (snap blank bit = 1) still spends its full ON slot, but anode_o stays all 1. Scan cadence does not depend on the blank mask.
- Hex decode (active-low, dp off), values 0..F:
  - 0..7: C0 F9 A4 B0 99 92 82 F8
  - 8..F: 80 90 88 83 C6 A1 86 8E
- dp set clears bit 7.
- All outputs are registered. anode_o and cathode_o change on the same edge, so no glitch combination is ever presented.

## Timing
- Reset (rst=0 at an edge) forces: state IDLE, `cnt`=0, idx=0, snapshots=0, anode_o=all 1, cathode_o=8'hFF, digit_idx_o=0, frame_tick_o=0.
- Reset mid-scan has the same effect; no partial slot completes.
- en sampled 1 at edge E0: BLANK from E0 to E0+dead_i+1, then ON for period_i+1 cycles.
- Frame length = NDIGITS × (dead_i + period_i + 2) cycles.
- frame_tick_o is high for exactly the one cycle following the last ON slot's final cycle. digit_idx_o reads 0 during that cycle.
- en sampled 0: outputs are all off from the next cycle. If en is re-asserted, scanning restarts at digit 0 with a fresh snapshot.
- Mid-frame changes to digits_i are invisible until the next frame_tick_o.

## Test plan
- Reset then idle: rst=0 for 2 cycles with en=0 → anode_o=4'hF, cathode_o=8'hFF, frame_tick_o=0 throughout.
- Basic scan:
  - Stimulus: NDIGITS=4, digits_i=16'h3210, period_i=3, dead_i=1, en=1.
  - Anode sequence per frame: E,F,F,D,F,F,B,F,F,7; each low strobe lasts 4 cycles, each gap 2 cycles.
  - Cathode per digit: digit0=C0, digit1=F9, digit2=A4, digit3=B0.
  - frame_tick_o pulses every 24 cycles.
- Decode sweep: cycle digits_i through 0..F on digit 0 with dp_i=1 → cathode equals the table value with bit 7 cleared (8 → 8'h00).
- Snapshot integrity: change digits_i from 16'h1111 to 16'h2222 while digit 1 is on → the remainder of that frame shows F9; 2222 (A4) appears only after frame_tick_o.
- Blank and en drop:
  - blank_i=4'b0100: anode bit 2 never goes low, but the frame length is unchanged.
  - Drop en mid-ON: the next cycle shows anode_o=F and cathode_o=FF.
  - Re-assert en: scanning restarts at digit 0.
- Reset mid-scan: assert rst=0 during digit 2's ON slot → the next cycle shows all reset values, and the scan resumes from digit 0.
